serial_adder: RTL and testbench

//   Parametrised bit-serial adder/subtractor. One full-adder cell plus a carry flop

---
 rtl/serial_adder.sv | 98 +++++++++
 tb/tb_serial_adder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop walk the
// operands LSB-first, one bit per clock, with a start/busy/done handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh, b_sh, res_fin;
  logic             carry, carry_nxt, s, last, accept;

  assign s         = a_sh[0] ^ b_sh[0] ^ carry;
  assign carry_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  assign last      = (cnt == CW'(WIDTH - 1));
  assign accept    = start && (state != RUN);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Partial result: bits arrive LSB-first and enter at the top, so after the
  // last shift the whole word lines up; only WIDTH-1 bits need storage.
  if (WIDTH == 1) begin : g_w1
    assign res_fin = s;
  end else begin : g_wn
    logic [WIDTH-2:0] res_sh;
    logic [WIDTH-1:0] res_cat;
    assign res_cat = {s, res_sh};
    assign res_fin = res_cat;
    always_ff @(posedge clk) begin
      if (rst)               res_sh <= '0;
      else if (state == RUN) res_sh <= res_cat[WIDTH-1:1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      // Subtract as a + ~b + ~borrow so the same cell serves both modes.
      a_sh  <= a;
      b_sh  <= sub ? ~b : b;
      carry <= cin ^ sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      carry <= carry_nxt;
      cnt   <= cnt + 1'b1;
      if (last) begin
        // carry here is the carry into the MSB; results only move on DONE entry.
        sum  <= res_fin;
        cout <= carry_nxt;
        ovf  <= carry ^ carry_nxt;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Randomized scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst, start, sub, cin;
  logic [7:0] a, b;
  logic       busy, done, cout, ovf;
  logic [7:0] sum;
  logic       start1, sub1, cin1;
  logic [0:0] a1, b1, sum1;
  logic       busy1, done1, cout1, ovf1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bcnt8 = 0;
  int bcnt1 = 0;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic exp_t model(input int w, input longint av, input longint bv,
                                 input int ci, input int sb, input int c);
    exp_t   e;
    longint m, half, r, sa, sbv, sr;
    m    = longint'(1) << w;
    half = m / 2;
    sa   = (av >= half) ? av - m : av;
    sbv  = (bv >= half) ? bv - m : bv;
    if (sb == 0) begin
      r      = av + bv + ci;
      e.cout = (r >= m);
      sr     = sa + sbv + ci;
    end else begin
      r      = av - bv - ci;
      e.cout = (r >= 0);
      sr     = sa - sbv - ci;
    end
    e.sum = 8'(((r % m) + m) % m);
    e.ovf = (sr < -half) || (sr >= half);
    e.cyc = c;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) bcnt8 = 0;
    else begin
      if (busy) bcnt8++;
      if (done) begin
        if (q8.size() == 0) chk("w8 spurious done", 32'd1, 32'd0);
        else begin
          e = q8.pop_front();
          chk("w8 sum", 32'(sum), 32'(e.sum));
          chk("w8 cout", 32'(cout), 32'(e.cout));
          chk("w8 ovf", 32'(ovf), 32'(e.ovf));
          chk("w8 done cycle", 32'(cyc), 32'(e.cyc));
          chk("w8 busy cycles", 32'(bcnt8), 32'd8);
        end
        bcnt8 = 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) bcnt1 = 0;
    else begin
      if (busy1) bcnt1++;
      if (done1) begin
        if (q1.size() == 0) chk("w1 spurious done", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          chk("w1 sum", 32'(sum1), 32'(e.sum[0]));
          chk("w1 cout", 32'(cout1), 32'(e.cout));
          chk("w1 ovf", 32'(ovf1), 32'(e.ovf));
          chk("w1 done cycle", 32'(cyc), 32'(e.cyc));
          chk("w1 busy cycles", 32'(bcnt1), 32'd1);
        end
        bcnt1 = 0;
      end
    end
  end

  task automatic wait_idle8();
    int t = 0;
    @(negedge clk);
    while (busy && t < 50) begin @(negedge clk); t++; end
    if (busy) chk("w8 idle timeout", 32'd1, 32'd0);
  endtask

  task automatic issue8(input logic [7:0] ia, input logic [7:0] ib, input logic ic, input logic is);
    wait_idle8();
    a = ia; b = ib; cin = ic; sub = is; start = 1'b1;
    @(posedge clk); #1;
    q8.push_back(model(8, ia, ib, ic, is, cyc + 8));
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic issue1(input logic ia, input logic ib, input logic ic, input logic is);
    int t = 0;
    @(negedge clk);
    while (busy1 && t < 50) begin @(negedge clk); t++; end
    if (busy1) chk("w1 idle timeout", 32'd1, 32'd0);
    a1 = ia; b1 = ib; cin1 = ic; sub1 = is; start1 = 1'b1;
    @(posedge clk); #1;
    q1.push_back(model(1, longint'(ia), longint'(ib), int'(ic), int'(is), cyc + 1));
    start1 = 1'b0;
    a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom); sub1 = 1'($urandom);
  endtask

  task automatic back_to_back8(input int n);
    wait_idle8();
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    start = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      q8.push_back(model(8, a, b, cin, sub, cyc + 8));
      if (i == n - 1) start = 1'b0;
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      if (i != n - 1) repeat (8) @(posedge clk);
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((q8.size() != 0 || q1.size() != 0) && t < 500) begin @(negedge clk); t++; end
    chk("drain pending", 32'(q8.size() + q1.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    start1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst sum", 32'(sum), 32'd0);
    chk("rst cout", 32'(cout), 32'd0);
    chk("rst ovf", 32'(ovf), 32'd0);
    chk("rst busy1", 32'(busy1), 32'd0);
    chk("rst sum1", 32'(sum1), 32'd0);
    rst = 1'b0;

    issue8(8'h3C, 8'h5A, 1'b0, 1'b0);
    issue8(8'hFF, 8'h01, 1'b0, 1'b0);
    issue8(8'hFF, 8'h01, 1'b1, 1'b0);
    issue8(8'h05, 8'h07, 1'b0, 1'b1);
    issue8(8'h80, 8'h01, 1'b0, 1'b1);
    issue8(8'h7F, 8'h80, 1'b1, 1'b1);
    for (int i = 0; i < 30; i++)
      issue8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    drain();

    // start re-pulsed mid-operation with different operands must be ignored
    issue8(8'h12, 8'h34, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    a = 8'hAA; b = 8'h55; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    back_to_back8(4);
    drain();

    // reset in the 4th RUN cycle aborts without a done pulse
    issue8(8'h9C, 8'h21, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    void'(q8.pop_back());
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort sum", 32'(sum), 32'd0);
    repeat (12) @(negedge clk);
    issue8(8'h40, 8'h40, 1'b0, 1'b0);
    drain();

    for (int i = 0; i < 8; i++) begin
      int v;
      v = i;
      issue1(v[2], v[1], v[0], 1'b0);
    end
    for (int i = 0; i < 8; i++)
      issue1(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
